count_sched: RTL



---
 rtl/count_sched_pkg.sv | 32 +++
 rtl/count_sched_arb.sv | 35 +++
 rtl/count_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/count_sched_pkg.sv
// rtl/count_sched_pkg.sv - shared types, constants and helpers for the count_sched interval scheduler
//
// Contents:
//   sched_state_t  : FSM state encoding (IDLE, LOAD, RUN, DONE), 2 bits
//   MAX_NUM_REQ    : upper bound on requesters; sizes index and pointer fields
//   IDX_W          : width of a requester index
//   onehot_to_idx  : converts a one-hot vector to a binary index
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    localparam int MAX_NUM_REQ = 8;
    localparam int IDX_W       = $clog2(MAX_NUM_REQ);

    // OR-reduction encoder; exact only for one-hot or all-zero inputs.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/count_sched_arb.sv
// rtl/count_sched_arb.sv - rotating-priority arbiter for the shared interval counter
//
// Module sched_arb (purely combinational).
// Ports:
//   req    in  NUM_REQ  pending requests
//   ptr    in  IDX_W    last winner; the search begins at ptr+1 and wraps modulo NUM_REQ
//   winner out NUM_REQ  one-hot winner, zero when no request is pending
// Holding ptr at NUM_REQ-1 gives fixed priority with requester 0 highest.
module sched_arb
    import count_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        // Visit candidates in rotated order; the first pending one wins.
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (j == (int'(ptr) + off) % NUM_REQ)) begin
                    winner[j] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/count_sched.sv
// rtl/count_sched.sv - time-multiplexed interval counter shared by several requesters
//
// Optional feature macro: COUNT_SCHED_RR_EN (round-robin arbitration; fixed priority if undefined).
// Ports:
//   clk        in  1                     system clock, rising edge
//   rst        in  1                     asynchronous active-high reset
//   req        in  NUM_REQ               level request per requester, held until its done pulse
//   req_val    in  NUM_REQ*NUM_CNT_BITS  terminal value per requester, slice i at [i*NUM_CNT_BITS +: NUM_CNT_BITS]
//   tick       in  1                     count qualifier
//   grant      out NUM_REQ               one-hot counter owner, zero when idle
//   done       out NUM_REQ               one-hot one-cycle completion pulse
//   busy       out 1                     counter owned
//   count_out  out NUM_CNT_BITS          current counter value
module count_sched
    import count_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int NUM_CNT_BITS = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*NUM_CNT_BITS-1:0] req_val,
    input  logic                            tick,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              done,
    output logic                            busy,
    output logic [NUM_CNT_BITS-1:0]         count_out
);

    sched_state_t              state;
    logic [NUM_REQ-1:0]        grant_q;
    logic [NUM_REQ-1:0]        done_q;
    logic [NUM_REQ-1:0]        winner;
    logic [NUM_CNT_BITS-1:0]   count_q;
    logic [NUM_CNT_BITS-1:0]   val_q;
    logic [NUM_CNT_BITS-1:0]   sel_val;
    logic [NUM_CNT_BITS-1:0]   count_inc;
    logic                      owner_req;

`ifdef COUNT_SCHED_RR_EN
    logic [IDX_W-1:0] ptr;
`else
    localparam logic [IDX_W-1:0] ptr = IDX_W'(NUM_REQ - 1);
`endif

    sched_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (ptr),
        .winner (winner)
    );

    // Terminal value of the current owner, selected by the one-hot grant.
    always_comb begin
        sel_val = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_q[j]) begin
                sel_val = req_val[j*NUM_CNT_BITS +: NUM_CNT_BITS];
            end
        end
    end

    // Owner still requesting; a drop during LOAD or RUN cancels the interval.
    assign owner_req = |(req & grant_q);
    assign count_inc = count_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            count_q <= '0;
            val_q   <= '0;
`ifdef COUNT_SCHED_RR_EN
            ptr     <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state   <= LOAD;
                        grant_q <= winner;
                        count_q <= '0;
                    end
                end
                LOAD: begin
                    if (!owner_req) begin
                        state   <= IDLE;
                        grant_q <= '0;
                        count_q <= '0;
                    end else begin
                        state <= RUN;
                        // Zero would never be reached after an increment; run one tick instead.
                        val_q <= (sel_val == '0) ? NUM_CNT_BITS'(1) : sel_val;
`ifdef COUNT_SCHED_RR_EN
                        ptr   <= onehot_to_idx(MAX_NUM_REQ'(grant_q));
`endif
                    end
                end
                RUN: begin
                    // Cancel takes precedence over a completion on the same edge.
                    if (!owner_req) begin
                        state   <= IDLE;
                        grant_q <= '0;
                        count_q <= '0;
                    end else if (tick) begin
                        count_q <= count_inc;
                        if (count_inc == val_q) begin
                            state  <= DONE;
                            done_q <= grant_q;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = (state != IDLE);
    assign count_out = count_q;

endmodule
